// File: rtl/sdram_emu_pkg.sv
// Shared encodings and helpers for the SDR SDRAM responder.
// Command encoding is {nRAS,nCAS,nWE}.
package sdram_emu_pkg;

  localparam logic [2:0] CMD_LOAD_MODE       = 3'b000;
  localparam logic [2:0] CMD_AUTO_REFRESH    = 3'b001;
  localparam logic [2:0] CMD_PRECHARGE       = 3'b010;
  localparam logic [2:0] CMD_ACTIVE          = 3'b011;
  localparam logic [2:0] CMD_WRITE           = 3'b100;
  localparam logic [2:0] CMD_READ            = 3'b101;
  localparam logic [2:0] CMD_BURST_TERMINATE = 3'b110;
  localparam logic [2:0] CMD_NOP             = 3'b111;

  localparam int ERR_BANK    = 0;
  localparam int ERR_TIMING  = 1;
  localparam int ERR_MODE    = 2;
  localparam int ERR_PREMODE = 3;
  localparam int ERR_COLLIDE = 4;
  localparam int ERR_W       = 5;

  // Timer width: must be able to represent TRC without saturating below it.
  localparam int TMR_W = 4;

  typedef enum logic {
    BANK_IDLE   = 1'b0,
    BANK_ACTIVE = 1'b1
  } bank_state_e;

  // Timer value seen at the next edge: 1 right after a restart, else count up and stick at max.
  function automatic logic [TMR_W-1:0] tmr_next(input logic restart, input logic [TMR_W-1:0] t);
    if (restart) return {{(TMR_W-1){1'b0}}, 1'b1};
    if (&t) return t;
    return t + 1'b1;
  endfunction

endpackage

// File: rtl/sdram_emu_bank.sv
// One SDRAM bank: IDLE/ACTIVE state, open row, cycles-since-ACTIVE timer
// and single-cycle error strobes for bank-state and tRCD/tRC violations.
module sdram_emu_bank
  import sdram_emu_pkg::*;
#(
  parameter int ROW_W = 4,
  parameter int TRCD  = 2,
  parameter int TRC   = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cke,
  input  logic             act,
  input  logic             rw,
  input  logic             pre,
  input  logic             auto_pre,
  input  logic [ROW_W-1:0] row_in,
  output bank_state_e      state,
  output logic [ROW_W-1:0] row,
  output logic             err_bank,
  output logic             err_timing
);

  bank_state_e      state_nxt;
  logic [TMR_W-1:0] tmr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= BANK_IDLE;
      row   <= '0;
      tmr   <= '1;
    end else if (cke) begin
      state <= state_nxt;
      if (act) row <= row_in;
      tmr <= tmr_next(act, tmr);
    end
  end

  always_comb begin
    state_nxt  = state;
    err_bank   = 1'b0;
    err_timing = 1'b0;
    if (act) begin
      // Re-activating an open bank is flagged but still relatches the row.
      state_nxt  = BANK_ACTIVE;
      err_bank   = (state == BANK_ACTIVE);
      err_timing = (tmr < TMR_W'(TRC));
    end else if (rw) begin
      if (state == BANK_IDLE) begin
        err_bank = 1'b1;
      end else begin
        err_timing = (tmr < TMR_W'(TRCD));
        if (auto_pre) state_nxt = BANK_IDLE;
      end
    end else if (pre) begin
      state_nxt = BANK_IDLE;
    end
  end

endmodule

// File: rtl/sdram_emu.sv
// SDR SDRAM responder: command decode, mode register, refresh tracking,
// block-RAM backing store and CAS-latency read pipeline.
module sdram_emu
  import sdram_emu_pkg::*;
#(
  parameter int ROW_W = 4,
  parameter int COL_W = 9,
  parameter int TRCD  = 2,
  parameter int TRC   = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sd_cke,
  input  logic             sd_ncs,
  input  logic             sd_nras,
  input  logic             sd_ncas,
  input  logic             sd_nwe,
  input  logic [1:0]       sd_ba,
  input  logic [12:0]      sd_a,
  input  logic [1:0]       sd_dqm,
  input  logic [15:0]      sd_dq_i,
  output logic [15:0]      sd_dq_o,
  output logic             sd_dq_oe,
  output logic             mode_ok,
  output logic [ERR_W-1:0] err,
  output logic [15:0]      rfs_cnt
);

  localparam int AW = 2 + ROW_W + COL_W;

  logic [2:0] cmd;
  logic       cmd_en;
  logic       is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;
  logic       mode_valid, any_active, sel_active, rd_go, wr_go, collide;
  logic [2:0] mode_cl;
  logic       cl3;
  logic [TMR_W-1:0] rfs_tmr;
  logic [ERR_W-1:0] err_set;
  logic [AW-1:0]    addr;
  logic             unused_a;

  bank_state_e      bst  [4];
  logic [ROW_W-1:0] brow [4];
  logic [3:0]       eb, et;

  logic [15:0] mem [1 << AW];
  logic [15:0] s0_data, s0_masked, s1_data;
  logic [1:0]  s0_dqm;
  logic        s0_v, s1_v;

  // sd_ncs=1 and sd_cke=0 both decode to NOP; BURST_TERMINATE matches nothing below.
  assign cmd    = {sd_nras, sd_ncas, sd_nwe};
  assign cmd_en = sd_cke & ~sd_ncs;
  assign is_act = cmd_en && (cmd == CMD_ACTIVE);
  assign is_rd  = cmd_en && (cmd == CMD_READ);
  assign is_wr  = cmd_en && (cmd == CMD_WRITE);
  assign is_pre = cmd_en && (cmd == CMD_PRECHARGE);
  assign is_ref = cmd_en && (cmd == CMD_AUTO_REFRESH);
  assign is_lmr = cmd_en && (cmd == CMD_LOAD_MODE);

  assign mode_valid = (sd_a[6:4] == 3'd2 || sd_a[6:4] == 3'd3) && (sd_a[2:0] == 3'd0);
  assign cl3        = (mode_cl == 3'd3);
  assign unused_a   = ^sd_a;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    sdram_emu_bank #(.ROW_W(ROW_W), .TRCD(TRCD), .TRC(TRC)) u_bank (
      .clk       (clk),
      .reset_n   (reset_n),
      .cke       (sd_cke),
      .act       (is_act && mode_ok && (sd_ba == 2'(b))),
      .rw        ((is_rd || is_wr) && mode_ok && (sd_ba == 2'(b))),
      .pre       (is_pre && (sd_a[10] || (sd_ba == 2'(b)))),
      .auto_pre  (sd_a[10]),
      .row_in    (sd_a[ROW_W-1:0]),
      .state     (bst[b]),
      .row       (brow[b]),
      .err_bank  (eb[b]),
      .err_timing(et[b])
    );
  end

  always_comb begin
    any_active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bst[i] == BANK_ACTIVE) any_active = 1'b1;
    end
  end

  assign sel_active = (bst[sd_ba] == BANK_ACTIVE);
  assign rd_go      = is_rd & mode_ok & sel_active;
  assign wr_go      = is_wr & mode_ok & sel_active;
  assign addr       = {sd_ba, brow[sd_ba], sd_a[COL_W-1:0]};
  // Data already on the bus, or queued to drive it under the current latency.
  assign collide    = is_wr & mode_ok & (sd_dq_oe | s0_v | (cl3 & s1_v));

  always_comb begin
    err_set              = '0;
    err_set[ERR_BANK]    = (|eb) | (is_lmr & any_active) | (is_ref & mode_ok & any_active);
    err_set[ERR_TIMING]  = (|et) | ((is_act | is_ref) & mode_ok & (rfs_tmr < TMR_W'(TRC)));
    err_set[ERR_MODE]    = is_lmr & ~mode_valid;
    err_set[ERR_PREMODE] = (is_act | is_rd | is_wr | is_ref) & ~mode_ok;
    err_set[ERR_COLLIDE] = collide;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_ok <= 1'b0;
      mode_cl <= 3'd2;
      err     <= '0;
      rfs_cnt <= '0;
      rfs_tmr <= '1;
    end else if (sd_cke) begin
      err <= err | err_set;
      if (is_lmr) begin
        mode_ok <= mode_valid;
        if (mode_valid) mode_cl <= sd_a[6:4];
      end
      if (is_ref && mode_ok && !(&rfs_cnt)) rfs_cnt <= rfs_cnt + 16'd1;
      rfs_tmr <= tmr_next(is_ref & mode_ok, rfs_tmr);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) begin
      if (!sd_dqm[0]) mem[addr][7:0]  <= sd_dq_i[7:0];
      if (!sd_dqm[1]) mem[addr][15:8] <= sd_dq_i[15:8];
    end
    if (sd_cke) s0_data <= mem[addr];
  end

  assign s0_masked = {s0_dqm[1] ? 8'h00 : s0_data[15:8], s0_dqm[0] ? 8'h00 : s0_data[7:0]};

  // CL=2 drives straight from the BRAM stage; CL=3 goes through s1 first.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s0_v     <= 1'b0;
      s0_dqm   <= '0;
      s1_v     <= 1'b0;
      s1_data  <= '0;
      sd_dq_o  <= '0;
      sd_dq_oe <= 1'b0;
    end else if (sd_cke) begin
      s0_v    <= rd_go;
      s0_dqm  <= sd_dqm;
      s1_v    <= s0_v;
      s1_data <= s0_masked;
      if (cl3) begin
        sd_dq_oe <= s1_v;
        sd_dq_o  <= s1_v ? s1_data : 16'h0000;
      end else begin
        sd_dq_oe <= s0_v;
        sd_dq_o  <= s0_v ? s0_masked : 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_sdram_emu.sv
// Directed bench for sdram_emu: init, write/readback, byte masks, CL=2/3,
// protocol and timing errors, bus collision and reset mid-read.
module tb_sdram_emu;

  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sd_cke, sd_ncs, sd_nras, sd_ncas, sd_nwe;
  logic [1:0]  sd_ba;
  logic [12:0] sd_a;
  logic [1:0]  sd_dqm;
  logic [15:0] sd_dq_i;
  logic [15:0] sd_dq_o;
  logic        sd_dq_oe;
  logic        mode_ok;
  logic [4:0]  err;
  logic [15:0] rfs_cnt;

  int checks   = 0;
  int failures = 0;

  sdram_emu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sd_cke  (sd_cke),
    .sd_ncs  (sd_ncs),
    .sd_nras (sd_nras),
    .sd_ncas (sd_ncas),
    .sd_nwe  (sd_nwe),
    .sd_ba   (sd_ba),
    .sd_a    (sd_a),
    .sd_dqm  (sd_dqm),
    .sd_dq_i (sd_dq_i),
    .sd_dq_o (sd_dq_o),
    .sd_dq_oe(sd_dq_oe),
    .mode_ok (mode_ok),
    .err     (err),
    .rfs_cnt (rfs_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pins_nop();
    sd_ncs  = 1'b1;
    {sd_nras, sd_ncas, sd_nwe} = 3'b111;
    sd_ba   = 2'd0;
    sd_a    = 13'd0;
    sd_dqm  = 2'b00;
    sd_dq_i = 16'h0000;
  endtask

  // Drive one command for the next rising edge; returns 1 ns after that edge.
  task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [1:0] dqm, input logic [15:0] dq);
    sd_ncs  = 1'b0;
    {sd_nras, sd_ncas, sd_nwe} = c;
    sd_ba   = ba;
    sd_a    = a;
    sd_dqm  = dqm;
    sd_dq_i = dq;
    @(posedge clk);
    #1;
    pins_nop();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called right after a READ edge k: data must be on the bus only between edges k+cl-1 and k+cl.
  task automatic expect_read(input string tag, input int cl, input logic [15:0] exp);
    check({tag, "_oe_early"}, 32'(sd_dq_oe), 32'd0);
    for (int i = 0; i < cl - 2; i++) begin
      idle(1);
      check({tag, "_oe_wait"}, 32'(sd_dq_oe), 32'd0);
    end
    idle(1);
    check({tag, "_oe"}, 32'(sd_dq_oe), 32'd1);
    check({tag, "_dq"}, 32'(sd_dq_o), 32'(exp));
    idle(1);
    check({tag, "_oe_after"}, 32'(sd_dq_oe), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    sd_cke  = 1'b1;
    pins_nop();
    idle(3);
    check("rst_dq_o", 32'(sd_dq_o), 32'd0);
    check("rst_oe", 32'(sd_dq_oe), 32'd0);
    check("rst_mode_ok", 32'(mode_ok), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rfs_cnt", 32'(rfs_cnt), 32'd0);
    reset_n = 1'b1;

    // Init: precharge all, mode CL=2 BL=1-word, then 8 refreshes spaced by tRC.
    issue(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0);
    issue(C_LMR, 2'd0, 13'h0220, 2'b00, 16'h0);
    check("init_mode_ok", 32'(mode_ok), 32'd1);
    for (int i = 0; i < 8; i++) begin
      issue(C_REF, 2'd0, 13'h0, 2'b00, 16'h0);
      idle(5);
    end
    check("init_rfs_cnt", 32'(rfs_cnt), 32'd8);
    check("init_err", 32'(err), 32'd0);

    // ACTIVE b1 row 3, WRITE+AP two cycles later, re-ACTIVE at tRC, READ.
    issue(C_ACT, 2'd1, 13'h0003, 2'b00, 16'h0);
    idle(1);
    issue(C_WR, 2'd1, 13'h0405, 2'b00, 16'hBEEF);
    idle(3);
    issue(C_ACT, 2'd1, 13'h0003, 2'b00, 16'h0);
    idle(1);
    issue(C_RD, 2'd1, 13'h0005, 2'b00, 16'h0);
    expect_read("rd_beef", 2, 16'hBEEF);
    check("rd_beef_err", 32'(err), 32'd0);

    // Low byte masked on write, high byte masked on read.
    issue(C_WR, 2'd1, 13'h0005, 2'b01, 16'h1234);
    issue(C_RD, 2'd1, 13'h0005, 2'b00, 16'h0);
    expect_read("rd_12ef", 2, 16'h12EF);
    issue(C_RD, 2'd1, 13'h0005, 2'b10, 16'h0);
    expect_read("rd_00ef", 2, 16'h00EF);
    check("mask_err", 32'(err), 32'd0);

    // READ one cycle after ACTIVE violates tRCD.
    issue(C_ACT, 2'd2, 13'h0001, 2'b00, 16'h0);
    issue(C_RD, 2'd2, 13'h0000, 2'b00, 16'h0);
    idle(3);
    check("trcd_err", 32'(err), 32'h02);

    // READ to an idle bank: bank-state error, bus never driven.
    issue(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0);
    issue(C_RD, 2'd0, 13'h0005, 2'b00, 16'h0);
    for (int i = 0; i < 3; i++) begin
      check("idle_rd_oe", 32'(sd_dq_oe), 32'd0);
      idle(1);
    end
    check("idle_rd_err", 32'(err), 32'h03);

    // CL=3: data valid at edge k+3.
    issue(C_LMR, 2'd0, 13'h0030, 2'b00, 16'h0);
    check("cl3_mode_ok", 32'(mode_ok), 32'd1);
    issue(C_ACT, 2'd1, 13'h0003, 2'b00, 16'h0);
    idle(1);
    issue(C_RD, 2'd1, 13'h0005, 2'b00, 16'h0);
    expect_read("rd_cl3", 3, 16'h12EF);
    check("cl3_err", 32'(err), 32'h03);

    // Unsupported burst length, then a READ before a valid mode.
    issue(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0);
    issue(C_LMR, 2'd0, 13'h0021, 2'b00, 16'h0);
    check("bl1_mode_ok", 32'(mode_ok), 32'd0);
    check("bl1_err", 32'(err), 32'h07);
    issue(C_RD, 2'd1, 13'h0005, 2'b00, 16'h0);
    idle(2);
    check("premode_oe", 32'(sd_dq_oe), 32'd0);
    check("premode_err", 32'(err), 32'h0F);

    // WRITE right behind a READ collides on the data bus.
    issue(C_LMR, 2'd0, 13'h0220, 2'b00, 16'h0);
    check("cl2_mode_ok", 32'(mode_ok), 32'd1);
    idle(6);
    issue(C_ACT, 2'd1, 13'h0003, 2'b00, 16'h0);
    idle(1);
    issue(C_RD, 2'd1, 13'h0005, 2'b00, 16'h0);
    issue(C_WR, 2'd1, 13'h0006, 2'b00, 16'h5555);
    check("collide_err", 32'(err), 32'h1F);
    idle(3);

    // Reset sampled one edge after a READ drops the pending word.
    issue(C_RD, 2'd1, 13'h0005, 2'b00, 16'h0);
    reset_n = 1'b0;
    idle(1);
    check("rstrd_oe_k1", 32'(sd_dq_oe), 32'd0);
    check("rstrd_err", 32'(err), 32'd0);
    check("rstrd_mode_ok", 32'(mode_ok), 32'd0);
    idle(1);
    check("rstrd_oe_k2", 32'(sd_dq_oe), 32'd0);
    check("rstrd_dq", 32'(sd_dq_o), 32'd0);
    reset_n = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
